lcd_text_buffer: RTL

Display-text store sitting directly upstream of the LCD main sequencer. It formats raw DS18B20 temperature words from the 1-wire reader into a 16-character ASCII line and writes it into a 4-line x 16-char text RAM. It serves the sequencer's level-held memory request / data-enabled read handshake.

---
 rtl/lcd_text_pkg.sv | 41 ++++
 rtl/lcd_text_sub_div.sv | 43 ++++
 rtl/lcd_text_buffer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_pkg.sv
// Shared types and ASCII constants for the LCD text buffer slice.
package lcd_text_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LATCH,
    ST_INT_DIG,
    ST_FRAC_DIG,
    ST_WRITE,
    ST_DONE
  } lcd_text_state_t;

  localparam int LINE_W   = 16;
  localparam int LINE_CNT = 4;

  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_PLUS       = 8'h2B;
  localparam logic [7:0] ASCII_MINUS      = 8'h2D;
  localparam logic [7:0] ASCII_DOT        = 8'h2E;
  localparam logic [7:0] ASCII_T          = 8'h54;
  localparam logic [7:0] ASCII_COLON      = 8'h3A;
  localparam logic [7:0] ASCII_C          = 8'h43;
  localparam logic [7:0] ASCII_N          = 8'h4E;

  localparam logic [8*12-1:0] ERR_TEXT = "T:SENSOR ERR";

  function automatic logic [7:0] err_char(input logic [3:0] col, input logic [7:0] fill);
    if (col < 4'd12) err_char = ERR_TEXT[8*(11-int'(col)) +: 8];
    else             err_char = fill;
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    digit_char = ASCII_DIGIT_BASE + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/lcd_text_sub_div.sv
// Serial decimal digit extractor: repeated subtraction of a constant divisor.
module lcd_text_sub_div (
  input  logic        LCD_TEXT_CLK,
  input  logic        LCD_TEXT_RESET_N,
  input  logic        start,
  input  logic [13:0] value,
  input  logic [13:0] divisor,
  output logic [3:0]  digit,
  output logic [13:0] remainder,
  output logic        done,
  output logic        busy
);

  logic        run_reg;
  logic [13:0] rem_reg;
  logic [3:0]  digit_reg;

  always_ff @(posedge LCD_TEXT_CLK or negedge LCD_TEXT_RESET_N) begin
    if (!LCD_TEXT_RESET_N) begin
      run_reg   <= 1'b0;
      rem_reg   <= '0;
      digit_reg <= '0;
    end else if (start) begin
      run_reg   <= 1'b1;
      rem_reg   <= value;
      digit_reg <= '0;
    end else if (run_reg) begin
      if (rem_reg >= divisor) begin
        rem_reg   <= rem_reg - divisor;
        digit_reg <= digit_reg + 4'd1;
      end else begin
        run_reg <= 1'b0;
      end
    end
  end

  // done is asserted for exactly one cycle, while digit/remainder are final
  assign done      = run_reg && (rem_reg < divisor);
  assign busy      = run_reg;
  assign digit     = digit_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/lcd_text_buffer.sv
// 4x16 LCD text RAM with DS18B20 temperature formatter.
// Optional macro LCD_TEXT_UPDATE_CNT_EN adds an update counter line.
module lcd_text_buffer #(
  parameter logic [1:0] TEMP_LINE   = 2'd0,
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  parameter logic [7:0] DEGREE_CHAR = 8'hDF
) (
  input  logic        LCD_TEXT_CLK,
  input  logic        LCD_TEXT_RESET_N,
  input  logic [15:0] TEMP_DATA,
  input  logic        TEMP_VALID,
  input  logic        TEMP_ERROR,
  input  logic        LCD_MAIN_MEMORY_REQUEST,
  input  logic [8:0]  LCD_MAIN_MEMORY_ADDRESS,
  output logic [7:0]  LCD_TEXT_DATA_OUT,
  output logic        LCD_TEXT_DATA_ENABLED,
  output logic        LCD_TEXT_BUSY,
  output logic        LCD_TEXT_UPDATED
);
  import lcd_text_pkg::*;

  lcd_text_state_t state_reg, state_next;
  logic [5:0]  clr_addr_reg;
  logic [4:0]  wr_cnt_reg;
  logic [1:0]  dig_idx_reg;
  logic        pending_reg, hold_err_reg, err_reg, sign_reg;
  logic [15:0] hold_data_reg, abs_val;
  logic [13:0] work_reg, frac_reg, divisor;
  logic [3:0]  int_h_reg, int_t_reg, int_u_reg;
  logic [3:0]  frac_dig_reg [4];
  logic [7:0]  data_out_reg, line_char, cnt_char, mem_wdata;
  logic [5:0]  mem_waddr;
  logic [1:0]  line_sel;
  logic        data_en_reg, mem_we, div_start, div_done, div_busy;
  logic [3:0]  div_digit;
  logic [13:0] div_rem;
  logic [7:0]  mem [LINE_W*LINE_CNT];

`ifdef LCD_TEXT_UPDATE_CNT_EN
  localparam logic [4:0] WR_LAST = 5'd31;
  logic [15:0] upd_cnt_reg;

  always_ff @(posedge LCD_TEXT_CLK or negedge LCD_TEXT_RESET_N) begin
    if (!LCD_TEXT_RESET_N)       upd_cnt_reg <= '0;
    else if (state_reg == ST_DONE) upd_cnt_reg <= upd_cnt_reg + 16'd1;
  end

  always_comb begin
    cnt_char = FILL_CHAR;
    case (wr_cnt_reg[3:0])
      4'd0: cnt_char = ASCII_N;
      4'd1: cnt_char = ASCII_COLON;
      4'd2: cnt_char = hex_char(upd_cnt_reg[15:12]);
      4'd3: cnt_char = hex_char(upd_cnt_reg[11:8]);
      4'd4: cnt_char = hex_char(upd_cnt_reg[7:4]);
      4'd5: cnt_char = hex_char(upd_cnt_reg[3:0]);
      default: cnt_char = FILL_CHAR;
    endcase
  end
`else
  localparam logic [4:0] WR_LAST = 5'd15;
  assign cnt_char = FILL_CHAR;
`endif

  always_ff @(posedge LCD_TEXT_CLK or negedge LCD_TEXT_RESET_N) begin
    if (!LCD_TEXT_RESET_N) state_reg <= ST_CLEAR;
    else                   state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR:    if (clr_addr_reg == 6'd63) state_next = ST_IDLE;
      ST_IDLE:     if (pending_reg) state_next = ST_LATCH;
      ST_LATCH:    state_next = hold_err_reg ? ST_WRITE : ST_INT_DIG;
      ST_INT_DIG:  if (div_done && dig_idx_reg == 2'd1) state_next = ST_FRAC_DIG;
      ST_FRAC_DIG: if (div_done && dig_idx_reg == 2'd2) state_next = ST_WRITE;
      ST_WRITE:    if (wr_cnt_reg == WR_LAST) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    LCD_TEXT_BUSY    = (state_reg != ST_IDLE);
    LCD_TEXT_UPDATED = (state_reg == ST_DONE);
    div_start = ((state_reg == ST_INT_DIG) || (state_reg == ST_FRAC_DIG)) && !div_busy;
    divisor   = 14'd10;
    if (state_reg == ST_INT_DIG && dig_idx_reg == 2'd0)  divisor = 14'd100;
    if (state_reg == ST_FRAC_DIG && dig_idx_reg == 2'd0) divisor = 14'd1000;
    if (state_reg == ST_FRAC_DIG && dig_idx_reg == 2'd1) divisor = 14'd100;
    mem_we = (state_reg == ST_CLEAR) || (state_reg == ST_WRITE);
  end

  lcd_text_sub_div u_div (
    .LCD_TEXT_CLK     (LCD_TEXT_CLK),
    .LCD_TEXT_RESET_N (LCD_TEXT_RESET_N),
    .start            (div_start),
    .value            (work_reg),
    .divisor          (divisor),
    .digit            (div_digit),
    .remainder        (div_rem),
    .done             (div_done),
    .busy             (div_busy)
  );

  // Leading zeros of the integer part are blanked; units always shown
  always_comb begin
    line_char = FILL_CHAR;
    if (err_reg) begin
      line_char = err_char(wr_cnt_reg[3:0], FILL_CHAR);
    end else begin
      case (wr_cnt_reg[3:0])
        4'd0:  line_char = ASCII_T;
        4'd1:  line_char = ASCII_COLON;
        4'd2:  line_char = sign_reg ? ASCII_MINUS : ASCII_PLUS;
        4'd3:  line_char = (int_h_reg == 4'd0) ? FILL_CHAR : digit_char(int_h_reg);
        4'd4:  line_char = (int_h_reg == 4'd0 && int_t_reg == 4'd0) ? FILL_CHAR : digit_char(int_t_reg);
        4'd5:  line_char = digit_char(int_u_reg);
        4'd6:  line_char = ASCII_DOT;
        4'd7:  line_char = digit_char(frac_dig_reg[0]);
        4'd8:  line_char = digit_char(frac_dig_reg[1]);
        4'd9:  line_char = digit_char(frac_dig_reg[2]);
        4'd10: line_char = digit_char(frac_dig_reg[3]);
        4'd11: line_char = DEGREE_CHAR;
        4'd12: line_char = ASCII_C;
        default: line_char = FILL_CHAR;
      endcase
    end
  end

  assign line_sel  = TEMP_LINE + {1'b0, wr_cnt_reg[4]};
  assign mem_waddr = (state_reg == ST_CLEAR) ? clr_addr_reg : {line_sel, wr_cnt_reg[3:0]};
  assign mem_wdata = (state_reg == ST_CLEAR) ? FILL_CHAR : (wr_cnt_reg[4] ? cnt_char : line_char);
  assign abs_val   = hold_data_reg[15] ? (~hold_data_reg + 16'd1) : hold_data_reg;

  always_ff @(posedge LCD_TEXT_CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge LCD_TEXT_CLK or negedge LCD_TEXT_RESET_N) begin
    if (!LCD_TEXT_RESET_N) begin
      clr_addr_reg  <= '0;
      wr_cnt_reg    <= '0;
      dig_idx_reg   <= '0;
      pending_reg   <= 1'b0;
      hold_data_reg <= '0;
      hold_err_reg  <= 1'b0;
      err_reg       <= 1'b0;
      sign_reg      <= 1'b0;
      work_reg      <= '0;
      frac_reg      <= '0;
      int_h_reg     <= '0;
      int_t_reg     <= '0;
      int_u_reg     <= '0;
      for (int i = 0; i < 4; i++) frac_dig_reg[i] <= '0;
      data_out_reg  <= 8'h00;
      data_en_reg   <= 1'b0;
    end else begin
      // A strobe in the LATCH cycle wins over the clear
      if (TEMP_VALID) begin
        pending_reg   <= 1'b1;
        hold_data_reg <= TEMP_DATA;
        hold_err_reg  <= TEMP_ERROR;
      end else if (state_reg == ST_LATCH) begin
        pending_reg <= 1'b0;
      end
      clr_addr_reg <= (state_reg == ST_CLEAR) ? clr_addr_reg + 6'd1 : 6'd0;
      wr_cnt_reg   <= (state_reg == ST_WRITE) ? wr_cnt_reg + 5'd1 : 5'd0;
      case (state_reg)
        ST_LATCH: begin
          err_reg     <= hold_err_reg;
          sign_reg    <= hold_data_reg[15];
          work_reg    <= {6'd0, abs_val[11:4]};
          frac_reg    <= {10'd0, abs_val[3:0]} * 14'd625;
          dig_idx_reg <= 2'd0;
        end
        ST_INT_DIG: if (div_done) begin
          if (dig_idx_reg == 2'd0) begin
            int_h_reg   <= div_digit;
            work_reg    <= div_rem;
            dig_idx_reg <= 2'd1;
          end else begin
            int_t_reg   <= div_digit;
            int_u_reg   <= div_rem[3:0];
            work_reg    <= frac_reg;
            dig_idx_reg <= 2'd0;
          end
        end
        ST_FRAC_DIG: if (div_done) begin
          frac_dig_reg[dig_idx_reg] <= div_digit;
          work_reg                  <= div_rem;
          if (dig_idx_reg == 2'd2) begin
            frac_dig_reg[3] <= div_rem[3:0];
            dig_idx_reg     <= 2'd0;
          end else begin
            dig_idx_reg <= dig_idx_reg + 2'd1;
          end
        end
        default: ;
      endcase
      if (LCD_MAIN_MEMORY_REQUEST && state_reg != ST_CLEAR) begin
        data_out_reg <= mem[LCD_MAIN_MEMORY_ADDRESS[5:0]];
        data_en_reg  <= 1'b1;
      end else begin
        data_en_reg <= 1'b0;
      end
    end
  end

  assign LCD_TEXT_DATA_OUT     = data_out_reg;
  assign LCD_TEXT_DATA_ENABLED = data_en_reg;

endmodule
